// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: source indices, register
// addresses, dispatch vectors and the priority helper.
package intc_pkg;

  localparam int NUM_INT = 5;

  typedef enum logic [2:0] {
    INT_VBLANK = 3'd0,
    INT_STAT   = 3'd1,
    INT_TIMER  = 3'd2,
    INT_SERIAL = 3'd3,
    INT_JOYPAD = 3'd4
  } int_idx_e;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam logic [7:0] VEC_VBLANK = 8'h40;
  localparam logic [7:0] VEC_STAT   = 8'h48;
  localparam logic [7:0] VEC_TIMER  = 8'h50;
  localparam logic [7:0] VEC_SERIAL = 8'h58;
  localparam logic [7:0] VEC_JOYPAD = 8'h60;

  // Isolates the lowest set bit; bit 0 (VBlank) has the highest priority.
  function automatic logic [NUM_INT-1:0] lowest_one(input logic [NUM_INT-1:0] v);
    return v & (~v + NUM_INT'(1));
  endfunction

endpackage

// File: rtl/intc_edge_detect.sv
// Rising-edge detector for the level request lines; samples every clk so no
// event is lost while the CPU is clock-gated.
module intc_edge_detect #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] src_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) src_q <= '0;
    else          src_q <= sig_i;
  end

  assign rise_o = sig_i & ~src_q;

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: IF/IE registers, edge-latched requests and ack clear.
// Optional STOP wake debounce is built only when INTC_STOP_WAKE_EN is defined.
module int_controller
  import intc_pkg::*;
#(
  parameter int WAKE_DEBOUNCE = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cpu_en,
  input  logic [4:0]   irq_src,
  input  logic         if_sel,
  input  logic         ie_sel,
  input  logic         bus_write,
  input  logic [7:0]   bus_wdata,
  output logic [7:0]   bus_rdata,
  input  logic         int_ack,
  output logic [4:0]   ints,
  input  logic         stop,
  output logic         stop_wake
);

  logic [NUM_INT-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [NUM_INT-1:0] rise;
  logic [NUM_INT-1:0] ack_mask;
  logic               wr_en;

  intc_edge_detect #(.WIDTH(NUM_INT)) u_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .sig_i  (irq_src),
    .rise_o (rise)
  );

  assign wr_en = bus_write & cpu_en;
  assign ints  = if_q & ie_q[NUM_INT-1:0];

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    ack_mask = '0;
    if (int_ack && cpu_en) ack_mask = lowest_one(ints);

    // A bus write overrides the ack clear; a fresh edge beats both.
    if_d = (wr_en && if_sel) ? bus_wdata[NUM_INT-1:0] : (if_q & ~ack_mask);
    if_d = if_d | rise;

    ie_d = (wr_en && ie_sel) ? bus_wdata : ie_q;
  end

  always_comb begin
    bus_rdata = 8'hFF;
    if (if_sel)      bus_rdata = {3'b111, if_q};
    else if (ie_sel) bus_rdata = ie_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_q <= '0;
      ie_q <= '0;
    end else begin
      if_q <= if_d;
      ie_q <= ie_d;
    end
  end

`ifdef INTC_STOP_WAKE_EN
  localparam int              CNT_W    = $clog2(WAKE_DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] WAKE_MAX = CNT_W'(WAKE_DEBOUNCE);

  logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;

  always_comb begin
    wake_cnt_d = '0;
    if (stop && irq_src[INT_JOYPAD])
      wake_cnt_d = (wake_cnt_q == WAKE_MAX) ? wake_cnt_q : wake_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wake_cnt_q <= '0;
    else          wake_cnt_q <= wake_cnt_d;
  end

  assign stop_wake = (wake_cnt_q == WAKE_MAX);
`else
  logic unused_stop;
  assign unused_stop = stop;
  assign stop_wake   = 1'b0;
`endif

endmodule

// File: tb/tb_int_controller.sv
// Directed scoreboard bench for int_controller; expected values are queued as
// stimulus is applied and popped when the matching output is sampled.
module tb_int_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_en;
  logic [4:0] irq_src;
  logic       if_sel;
  logic       ie_sel;
  logic       bus_write;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       int_ack;
  logic [4:0] ints;
  logic       stop;
  logic       stop_wake;

  int tests_run = 0;
  int failures  = 0;
  logic [7:0] sb_q[$];

  int_controller #(.WAKE_DEBOUNCE(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_en   (cpu_en),
    .irq_src  (irq_src),
    .if_sel   (if_sel),
    .ie_sel   (ie_sel),
    .bus_write(bus_write),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .int_ack  (int_ack),
    .ints     (ints),
    .stop     (stop),
    .stop_wake(stop_wake)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    tests_run++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic bus_wr(input logic sel_if, input logic [7:0] data);
    if_sel    = sel_if;
    ie_sel    = ~sel_if;
    bus_write = 1'b1;
    bus_wdata = data;
    tick();
    if_sel    = 1'b0;
    ie_sel    = 1'b0;
    bus_write = 1'b0;
  endtask

  task automatic read_reg(input logic sel_if, input logic sel_ie, output logic [7:0] v);
    if_sel = sel_if;
    ie_sel = sel_ie;
    #1;
    v = bus_rdata;
    if_sel = 1'b0;
    ie_sel = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    reset_n = 1'b0; cpu_en = 1'b1; irq_src = '0; if_sel = 1'b0; ie_sel = 1'b0;
    bus_write = 1'b0; bus_wdata = '0; int_ack = 1'b0; stop = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    push_exp(8'h00); check("rst_ints", {3'b0, ints});
    push_exp(8'h00); check("rst_wake", {7'b0, stop_wake});
    push_exp(8'hFF); read_reg(1'b0, 1'b0, rd); check("rst_rd_none", rd);

    // Reset mid-traffic
    bus_wr(1'b0, 8'hFF);
    bus_wr(1'b1, 8'h1F);
    push_exp(8'h1F); check("pre_rst_ints", {3'b0, ints});
    reset_n = 1'b0;
    #1;
    push_exp(8'h00); check("midrst_ints", {3'b0, ints});
    push_exp(8'hE0); read_reg(1'b1, 1'b0, rd); check("midrst_if", rd);
    push_exp(8'h00); read_reg(1'b0, 1'b1, rd); check("midrst_ie", rd);
    tick();
    reset_n = 1'b1;
    tick();

    // Single source, level held: set once, cleared by ack, no retrigger
    bus_wr(1'b0, 8'h01);
    irq_src = 5'h01;
    tick();
    push_exp(8'hE1); read_reg(1'b1, 1'b0, rd); check("lvl_if_set", rd);
    push_exp(8'h01); check("lvl_ints", {3'b0, ints});
    repeat (3) tick();
    ack();
    push_exp(8'hE0); read_reg(1'b1, 1'b0, rd); check("lvl_if_acked", rd);
    repeat (5) tick();
    push_exp(8'hE0); read_reg(1'b1, 1'b0, rd); check("lvl_no_retrig", rd);
    push_exp(8'h00); check("lvl_ints_clr", {3'b0, ints});
    irq_src = 5'h00;
    tick();

    // Priority: lowest bit serviced first
    bus_wr(1'b0, 8'h1F);
    bus_wr(1'b1, 8'h05);
    ack();
    push_exp(8'hE4); read_reg(1'b1, 1'b0, rd); check("prio_if_1", rd);
    push_exp(8'h04); check("prio_ints_1", {3'b0, ints});
    ack();
    push_exp(8'hE0); read_reg(1'b1, 1'b0, rd); check("prio_if_2", rd);

    // Ack + new edge + bus write in the same cycle
    bus_wr(1'b1, 8'h01);
    int_ack   = 1'b1;
    irq_src   = 5'h01;
    if_sel    = 1'b1;
    bus_write = 1'b1;
    bus_wdata = 8'h02;
    tick();
    int_ack = 1'b0; if_sel = 1'b0; bus_write = 1'b0;
    push_exp(8'hE3); read_reg(1'b1, 1'b0, rd); check("collide_if", rd);
    push_exp(8'hE3); read_reg(1'b1, 1'b1, rd); check("both_sel_if_wins", rd);
    irq_src = 5'h00;
    tick();

    // Ack with nothing enabled is a no-op; cpu_en gates writes and ack
    bus_wr(1'b0, 8'h00);
    bus_wr(1'b1, 8'h1F);
    ack();
    push_exp(8'hFF); read_reg(1'b1, 1'b0, rd); check("ack_noop_if", rd);
    push_exp(8'h00); check("ack_noop_ints", {3'b0, ints});
    cpu_en = 1'b0;
    bus_wr(1'b0, 8'hA5);
    push_exp(8'h00); read_reg(1'b0, 1'b1, rd); check("gated_ie_wr", rd);
    bus_wr(1'b0, 8'h1F);
    push_exp(8'h00); read_reg(1'b0, 1'b1, rd); check("gated_ie_wr2", rd);
    cpu_en = 1'b1;
    bus_wr(1'b0, 8'hA5);
    push_exp(8'hA5); read_reg(1'b0, 1'b1, rd); check("ie_all_bits", rd);
    bus_wr(1'b0, 8'h1F);
    cpu_en = 1'b0;
    ack();
    push_exp(8'hFF); read_reg(1'b1, 1'b0, rd); check("gated_ack", rd);
    cpu_en = 1'b1;

    // STOP wake debounce
    stop    = 1'b1;
    irq_src = 5'h10;
    repeat (15) tick();
    push_exp(8'h00); check("wake_15", {7'b0, stop_wake});
    irq_src = 5'h00;
    tick();
    push_exp(8'h00); check("wake_drop", {7'b0, stop_wake});
    irq_src = 5'h10;
    repeat (16) tick();
`ifdef INTC_STOP_WAKE_EN
    push_exp(8'h01);
`else
    push_exp(8'h00);
`endif
    check("wake_16", {7'b0, stop_wake});
    stop = 1'b0;
    tick();
    push_exp(8'h00); check("wake_stop_low", {7'b0, stop_wake});
    irq_src = 5'h00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
